// File: rtl/alu1_pkg.sv
// Shared definitions for the alu1_xbar_pe tile: opcodes, crossbar source
// selects, and the layout of the 13-bit serial configuration chain.
package alu1_pkg;

  localparam int unsigned CHAIN_W  = 13;
  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned OSEL_LSB = 4;
  localparam int unsigned XSEL_W   = 2;
  localparam int unsigned X0_LSB   = 5;
  localparam int unsigned X1_LSB   = 7;
  localparam int unsigned X2_LSB   = 9;
  localparam int unsigned X3_LSB   = 11;
  localparam int unsigned SHAMT_W  = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_SRA   = 4'd8,
    OP_EQ    = 4'd9,
    OP_SLT   = 4'd10,
    OP_ULT   = 4'd11,
    OP_PASSA = 4'd12,
    OP_PASSB = 4'd13,
    OP_MIN   = 4'd14,
    OP_ZERO  = 4'd15
  } op_e;

  typedef enum logic [XSEL_W-1:0] {
    SRC_IN0  = 2'd0,
    SRC_IN1  = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_HOLD = 2'd3
  } src_e;

  // Field view of the chain; member order matches the bit positions above.
  typedef struct packed {
    src_e       x3_sel;
    src_e       x2_sel;
    src_e       x1_sel;
    src_e       x0_sel;
    logic       out_sel;
    op_e        op;
  } cfg_t;

endpackage

// File: rtl/alu1_core.sv
// Combinational opcode evaluator for the alu1 tile.
// Define ALU1_MUL_EN to build the multiplier for OP_MUL; otherwise OP_MUL
// returns 0.
// Ports:
//   op_i    - opcode
//   a_i     - operand a
//   b_i     - operand b (b_i[4:0] is the shift amount)
//   res_c_o - combinational result, wraps modulo 2^SIZE
module alu1_core
  import alu1_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  op_e             op_i,
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  output logic [SIZE-1:0] res_c_o
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt_s;
  logic               lt_u;
  logic               eq;

  assign shamt = b_i[SHAMT_W-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  assign eq    = a_i == b_i;

  // Opcode select; comparisons are zero-extended single bits.
  always_comb begin
    res_c_o = '0;
    case (op_i)
      OP_ADD:   res_c_o = a_i + b_i;
      OP_SUB:   res_c_o = a_i - b_i;
`ifdef ALU1_MUL_EN
      OP_MUL:   res_c_o = a_i * b_i;
`else
      OP_MUL:   res_c_o = '0;
`endif
      OP_AND:   res_c_o = a_i & b_i;
      OP_OR:    res_c_o = a_i | b_i;
      OP_XOR:   res_c_o = a_i ^ b_i;
      OP_SHL:   res_c_o = a_i << shamt;
      OP_SHR:   res_c_o = a_i >> shamt;
      OP_SRA:   res_c_o = $unsigned($signed(a_i) >>> shamt);
      OP_EQ:    res_c_o = {{(SIZE-1){1'b0}}, eq};
      OP_SLT:   res_c_o = {{(SIZE-1){1'b0}}, lt_s};
      OP_ULT:   res_c_o = {{(SIZE-1){1'b0}}, lt_u};
      OP_PASSA: res_c_o = a_i;
      OP_PASSB: res_c_o = b_i;
      OP_MIN:   res_c_o = lt_s ? a_i : b_i;
      OP_ZERO:  res_c_o = '0;
      default:  res_c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu1_xbar_pe.sv
// CGRA compute tile: 4x4 input crossbar -> registered ALU plus a single-entry
// hold register, with a 2:1 output switch. All selects and the opcode live
// in a 13-bit serial configuration chain (first bit sent lands in chain[12]).
// Optional macro: ALU1_MUL_EN enables the multiplier for opcode 2.
// Ports:
//   clk        - system clock (datapath and chain)
//   reset      - asynchronous active-low reset
//   config_en  - shift the chain one bit per edge
//   config_in  - serial configuration input
//   config_out - serial configuration output (chain[12])
//   in0, in1   - neighbour tile data
//   out0       - tile result, combinational from alu_q/hold_q
// SIZE must be at least 8.
module alu1_xbar_pe
  import alu1_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            config_en,
  input  logic            config_in,
  output logic            config_out,
  input  logic [SIZE-1:0] in0,
  input  logic [SIZE-1:0] in1,
  output logic [SIZE-1:0] out0
);

  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic [SIZE-1:0]    alu_q, alu_d;
  logic [SIZE-1:0]    hold_q, hold_d;
  logic [SIZE-1:0]    x0, x1, x2;
  logic               hold_en;
  cfg_t               cfg;

  assign cfg = cfg_t'(chain_q);

  // Crossbar source mux; feedback inputs are registers so no comb loop.
  function automatic logic [SIZE-1:0] xsel(input src_e s,
                                           input logic [SIZE-1:0] a0,
                                           input logic [SIZE-1:0] a1,
                                           input logic [SIZE-1:0] a2,
                                           input logic [SIZE-1:0] a3);
    logic [SIZE-1:0] r;
    r = a0;
    case (s)
      SRC_IN0:  r = a0;
      SRC_IN1:  r = a1;
      SRC_ALU:  r = a2;
      SRC_HOLD: r = a3;
      default:  r = a0;
    endcase
    return r;
  endfunction

  assign x0 = xsel(cfg.x0_sel, in0, in1, alu_q, hold_q);
  assign x1 = xsel(cfg.x1_sel, in0, in1, alu_q, hold_q);
  assign x2 = xsel(cfg.x2_sel, in0, in1, alu_q, hold_q);

  // Only bit 0 of x3 is consumed (hold write enable), so mux just that bit.
  always_comb begin
    hold_en = in0[0];
    case (cfg.x3_sel)
      SRC_IN0:  hold_en = in0[0];
      SRC_IN1:  hold_en = in1[0];
      SRC_ALU:  hold_en = alu_q[0];
      SRC_HOLD: hold_en = hold_q[0];
      default:  hold_en = in0[0];
    endcase
  end

  alu1_core #(.SIZE(SIZE)) u_core (
    .op_i    (cfg.op),
    .a_i     (x0),
    .b_i     (x1),
    .res_c_o (alu_d)
  );

  // Next-state for chain and hold; datapath sees the pre-edge chain.
  always_comb begin
    chain_d = chain_q;
    hold_d  = hold_q;
    if (config_en) begin
      chain_d = {chain_q[CHAIN_W-2:0], config_in};
    end
    if (hold_en) begin
      hold_d = x2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q <= '0;
      alu_q   <= '0;
      hold_q  <= '0;
    end else begin
      chain_q <= chain_d;
      alu_q   <= alu_d;
      hold_q  <= hold_d;
    end
  end

  assign config_out = chain_q[CHAIN_W-1];
  assign out0       = cfg.out_sel ? hold_q : alu_q;

endmodule

// File: tb/tb_alu1_xbar_pe.sv
// Directed self-checking bench for alu1_xbar_pe (SIZE=32).
module tb_alu1_xbar_pe;

  logic        clk;
  logic        reset;
  logic        config_en;
  logic        config_in;
  logic        config_out;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [31:0] out0;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [12:0] chain_m;

  alu1_xbar_pe #(.SIZE(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .in0        (in0),
    .in1        (in1),
    .out0       (out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift a 13-bit word MSB first; config_out is checked after every shift.
  task automatic load_cfg(input logic [12:0] cfg);
    config_en = 1'b1;
    for (int i = 12; i >= 0; i--) begin
      config_in = cfg[i];
      step();
      chain_m = {chain_m[11:0], cfg[i]};
      check("config_out", {31'd0, config_out}, {31'd0, chain_m[12]});
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    chain_m = '0;
    #3;
    reset = 1'b1;
    #1;
  endtask

  // Config word: {x3, x2, x1, x0, out_sel, op}
  function automatic logic [12:0] mk(input logic [1:0] x3, input logic [1:0] x2,
                                     input logic [1:0] x1, input logic [1:0] x0,
                                     input logic osel, input logic [3:0] op);
    return {x3, x2, x1, x0, osel, op};
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] mul_exp;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    chain_m   = '0;
    reset     = 1'b0;
    config_en = 1'b0;
    config_in = 1'b0;
    in0       = '0;
    in1       = '0;
    #12;
    reset = 1'b1;
    #1;

    // Reset: run, then assert asynchronously mid-cycle.
    in0 = 32'd9;
    step();
    step();
    check("pre_reset_add", out0, 32'd18);
    #2;
    reset = 1'b0;
    chain_m = '0;
    #1;
    check("reset_out0", out0, 32'd0);
    check("reset_cfg_out", {31'd0, config_out}, 32'd0);
    #1;
    reset = 1'b1;
    in0 = 32'd5;
    step();
    check("post_reset_add", out0, 32'd10);

    // Accumulator: start from a clean reset with zero inputs while shifting.
    in0 = '0;
    in1 = '0;
    do_reset();
    load_cfg(mk(2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0));
    check("acc_start", out0, 32'd0);
    in1 = 32'd2;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("acc", out0, 32'(2 * k));
    end

    // Subtract: x0=in0, x1=in1, out from alu.
    load_cfg(mk(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 4'd1));
    in0 = 32'd3;
    in1 = 32'd5;
    step();
    check("sub", out0, 32'hFFFF_FFFE);

    // Chain replay: a config with bit 12 set shows up on config_out after 13 shifts.
    load_cfg(mk(2'd2, 2'd0, 2'd1, 2'd0, 1'b0, 4'd1));
    check("replay_first_bit", {31'd0, config_out}, 32'd1);

    // Hold: x2=in0, x3=in1, out from hold.
    load_cfg(mk(2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0));
    in0 = 32'h0000_00A5;
    in1 = 32'd1;
    step();
    check("hold_capture", out0, 32'h0000_00A5);
    in0 = 32'h0000_0011;
    in1 = 32'd0;
    step();
    check("hold_keep", out0, 32'h0000_00A5);
    step();
    check("hold_keep2", out0, 32'h0000_00A5);

`ifdef ALU1_MUL_EN
    mul_exp = 32'd42;
`else
    mul_exp = 32'd0;
`endif

    vecs.push_back('{4'd10, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt"});
    vecs.push_back('{4'd11, 32'hFFFF_FFFF, 32'd1, 32'd0, "ult"});
    vecs.push_back('{4'd8,  32'h8000_0000, 32'd4, 32'hF800_0000, "sra"});
    vecs.push_back('{4'd7,  32'h8000_0000, 32'd4, 32'h0800_0000, "shr"});
    vecs.push_back('{4'd6,  32'h0000_0003, 32'h0000_0024, 32'h0000_0030, "shl_b40"});
    vecs.push_back('{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor"});
    vecs.push_back('{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and"});
    vecs.push_back('{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, "or"});
    vecs.push_back('{4'd9,  32'h0000_1234, 32'h0000_1234, 32'd1, "eq"});
    vecs.push_back('{4'd14, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFE, "min"});
    vecs.push_back('{4'd12, 32'h0000_AAAA, 32'h0000_5555, 32'h0000_AAAA, "pass_a"});
    vecs.push_back('{4'd13, 32'h0000_AAAA, 32'h0000_5555, 32'h0000_5555, "pass_b"});
    vecs.push_back('{4'd15, 32'h0000_AAAA, 32'h0000_5555, 32'd0, "zero"});
    vecs.push_back('{4'd0,  32'hFFFF_FFFF, 32'd2, 32'd1, "add_wrap"});
    vecs.push_back('{4'd2,  32'd7, 32'd6, mul_exp, "mul"});

    foreach (vecs[i]) begin
      load_cfg(mk(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, vecs[i].op));
      in0 = vecs[i].a;
      in1 = vecs[i].b;
      step();
      check(vecs[i].tag, out0, vecs[i].exp);
    end

    // Reset mid-shift discards the partial configuration.
    config_en = 1'b1;
    config_in = 1'b1;
    step();
    step();
    config_en = 1'b0;
    do_reset();
    check("midshift_cfg_out", {31'd0, config_out}, 32'd0);
    in0 = 32'd21;
    in1 = 32'd100;
    step();
    check("midshift_default_add", out0, 32'd42);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu1_xbar_pe.md
# alu1_xbar_pe

Configurable processing-element slice: a 4x4 input crossbar feeds a registered 4-bit-opcode ALU and a single-entry hold register, and a 2:1 output switch selects which one drives the block output. All selection and opcode state lives in one 13-bit serial configuration chain clocked by the system clock. It is the compute tile instantiated in each CGRA array cell. Neighbour tiles drive `in0`/`in1`, and the chain is daisy-chained through `config_in`/`config_out`.

## Interface
- `SIZE`, default 32: datapath width in bits; must be ≥ 8.
- `clk` — input, 1 bit: the single clock for datapath and configuration.
- `reset` — input, 1 bit: asynchronous, active-low reset.
- `config_en` — input, 1 bit: when high, the configuration chain shifts by one bit per `clk` edge.
- `config_in` — input, 1 bit: serial configuration input.
- `config_out` — output, 1 bit: serial configuration output, equal to `chain[12]`.
- `in0`, `in1` — input, `SIZE` bits each: data from neighbour tiles.
- `out0` — output, `SIZE` bits: block result.

## Operation
- **Chain shift:** on each edge with `config_en`=1, `chain <= {chain[11:0], config_in}`. Loading takes 13 shifts; the bit destined for `chain[12]` is sent first.
- **Chain fields:**
  - `chain[3:0]` = ALU opcode.
  - `chain[4]` = output select: 0 selects `alu_q`, 1 selects `hold_q`.
  - `chain[6:5]`, `[8:7]`, `[10:9]`, `[12:11]` = crossbar selects for `x0`, `x1`, `x2`, `x3`.
- **Crossbar:** combinational. Select values map as 0 = `in0`, 1 = `in1`, 2 = `alu_q`, 3 = `hold_q`. There are no combinational loops, because the feedback sources are registers.
- **ALU:** operands `a`=`x0`, `b`=`x1`. Every edge, `alu_q` <= result of the opcode:
  - 0: a+b
  - 1: a−b
  - 2: low `SIZE` bits of a*b
  - 3: a&b
  - 4: a|b
  - 5: a^b
  - 6: a<<b[4:0]
  - 7: a>>b[4:0] (logical)
  - 8: a>>>b[4:0] (arithmetic)
  - 9: (a==b)
  - 10: signed a<b
  - 11: unsigned a<b
  - 12: a
  - 13: b
  - 14: signed min(a,b)
  - 15: 0
- **Comparison results** are zero-extended 1/0.
- **Arithmetic width:** results wrap modulo 2^SIZE and there is no overflow flag. The shift amount uses `b[4:0]` regardless of `SIZE`.
- **Hold register:** on each edge, if `x3[0]`=1 then `hold_q <= x2`; otherwise it keeps its value.
- **Output:** `out0` = `chain[4]` ? `hold_q` : `alu_q`, combinational from the registers.

## Timing
- **Reset (`reset`=0):** immediately clears `chain`, `alu_q` and `hold_q` to 0. Therefore `out0`=0 and `config_out`=0. The post-reset configuration is an add of `in0`+`in0`, output from `alu_q`.
- **ALU latency:** 1 cycle, from inputs to `alu_q`.
- **Hold path:** from input to `hold_q` takes 1 cycle; from `hold_q` to `out0` is combinational.
- **Configuration timing:** fields take effect combinationally as soon as `chain` changes. During shifting the datapath keeps clocking using partially shifted fields; results produced while `config_en`=1 are undefined for the user but must not be X.
- **Reset mid-shift:** discards the partial configuration; all fields return to 0.
- **Simultaneous events:** `config_en` and datapath updates occur on the same edge independently. The datapath uses the pre-edge chain value.

## Configuration
- Macro `ALU1_MUL_EN`:
  - Defined: opcode 2 computes the low `SIZE` bits of the product.
  - Undefined: opcode 2 returns 0 and no multiplier is synthesized.
  - All other opcodes are unaffected either way.

## Structure
- **Shared package `alu1_pkg`:**
  - opcode enum (`OP_ADD`..`OP_ZERO`)
  - crossbar select enum (`SRC_IN0`, `SRC_IN1`, `SRC_ALU`, `SRC_HOLD`)
  - `CHAIN_W`=13
  - field LSB/width constants
- **One sub-module:** `alu1_core`, the combinational opcode evaluator parameterized by `SIZE`. The crossbar, registers and chain stay in the top level.

## Test plan
1. **Reset:** assert `reset`=0 mid-operation → `out0`=0 and `config_out`=0 immediately. After release, with `in0`=5, the next edge gives `out0`=10.
2. **Subtract:**
   - Shift op=1, `x0`=`in0`, `x1`=`in1`, out sel 0.
   - `in0`=3, `in1`=5 → one cycle later `out0`=0xFFFFFFFE.
   - `config_out` must replay the first-sent bit on the 14th shift.
3. **Accumulator:**
   - op=0, `x0`=`SRC_ALU`, `x1`=`in1`.
   - `in1`=2 held → `out0` counts 2, 4, 6, 8 on successive cycles.
4. **Hold:**
   - `x2`=`in0`, `x3`=`in1`, out sel 1.
   - `in0`=0xA5, `in1`=1 → 0xA5 appears after one edge.
   - Then `in1`=0, `in0`=0x11 → `out0` remains 0xA5.
5. **Signed ops:**
   - op 10 with a=0xFFFFFFFF, b=1 → 1.
   - op 11 with the same operands → 0.
   - op 8 with a=0x80000000, b=4 → 0xF8000000.
6. **Multiply:** op 2 with 7*6 → 42 with `ALU1_MUL_EN` defined, 0 without it.
